rhythm_judge: RTL

Parametrised N-lane falling-note judge engine for the mania game core. Streams a chart from a row-organised ROM into per-lane shift-register tracks, scrolls the notes toward a hit line, and grades key press edges against a configurable timing window (PERFECT/GREAT/MISS). It accumulates score, combo and max combo for the display and HUD logic, and exports the tracks for the renderer.

---
 rtl/rhythm_judge.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/rhythm_judge.sv
// N-lane falling-note judge: streams a chart into per-lane tracks, grades key presses, keeps score.
// Optional autoplay input is enabled by defining RHYTHM_JUDGE_AUTOPLAY_EN.
module rhythm_judge #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned DEPTH      = 480,
  parameter int unsigned HIT_ROW    = 445,
  parameter int unsigned WIN        = 4,
  parameter int unsigned STEP_DIV   = 1000,
  parameter int unsigned READ_STEPS = 40,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LANES-1:0]         key,
`ifdef RHYTHM_JUDGE_AUTOPLAY_EN
  input  logic                     autoplay,
`endif
  output logic [ADDR_W-1:0]        chart_addr,
  input  logic [LANES-1:0]         chart_data,
  input  logic                     chart_end,
  output logic [LANES*DEPTH-1:0]   track,
  output logic [LANES-1:0]         judge_valid,
  output logic [2*LANES-1:0]       judge_grade,
  output logic [31:0]              score,
  output logic [15:0]              combo,
  output logic [15:0]              max_combo,
  output logic                     busy,
  output logic                     done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int unsigned CYC_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned RD_W    = (READ_STEPS > 1) ? $clog2(READ_STEPS) : 1;
  localparam int unsigned WIN_LO  = HIT_ROW - WIN;
  localparam int unsigned WIN_HI  = HIT_ROW + WIN;
  localparam int unsigned PERF_LO = HIT_ROW - WIN / 2;
  localparam int unsigned PERF_HI = HIT_ROW + WIN / 2;

  logic [1:0]             state_q, state_d;
  logic                   fetch_q;
  logic [1:0]             refill_q;
  logic [CYC_W-1:0]       cyc_q;
  logic [RD_W-1:0]        rd_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [LANES-1:0]       next_row_q, key_q;
  logic                   next_end_q;
  logic [LANES*DEPTH-1:0] track_q, track_d;
  logic [LANES-1:0]       jv_q, jv_d;
  logic [2*LANES-1:0]     jg_q, jg_d;
  logic [31:0]            score_q, score_d, add_score;
  logic [15:0]            combo_q, combo_d, max_q, max_d, add_combo, combo_base;
  logic [32:0]            score_sum;
  logic [16:0]            combo_sum;
  logic                   run, step, inject, restart, auto_on;
  logic [LANES-1:0]       press, hit, perf, miss;
  logic [DEPTH-1:0]       lane_v, sel;

`ifdef RHYTHM_JUDGE_AUTOPLAY_EN
  assign auto_on = autoplay;
`else
  assign auto_on = 1'b0;
`endif

  assign run     = (state_q == ST_RUN);
  assign step    = run && (cyc_q == CYC_W'(STEP_DIV - 1));
  assign inject  = step && (rd_q == '0) && !next_end_q;
  assign restart = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign press   = key & ~key_q;

  // Per lane: judge against the pre-shift track, then miss-clear, then shift.
  always_comb begin
    track_d   = track_q;
    hit       = '0;
    perf      = '0;
    miss      = '0;
    jv_d      = '0;
    jg_d      = '0;
    add_score = '0;
    add_combo = '0;
    lane_v    = '0;
    sel       = '0;
    if (run) begin
      for (int l = 0; l < LANES; l++) begin
        lane_v = track_q[l*DEPTH +: DEPTH];
        sel    = '0;
        if (auto_on) begin
          if (lane_v[HIT_ROW]) begin
            hit[l]       = 1'b1;
            perf[l]      = 1'b1;
            sel[HIT_ROW] = 1'b1;
          end
        end else if (press[l]) begin
          // Ascending scan so the highest-index note wins.
          for (int unsigned r = WIN_LO; r <= WIN_HI; r++) begin
            if (lane_v[r]) begin
              sel     = '0;
              sel[r]  = 1'b1;
              hit[l]  = 1'b1;
              perf[l] = (r >= PERF_LO) && (r <= PERF_HI);
            end
          end
        end
        lane_v  = lane_v & ~sel;
        miss[l] = step && !auto_on && lane_v[WIN_HI];
        if (miss[l]) lane_v[WIN_HI] = 1'b0;
        if (step) lane_v = {lane_v[DEPTH-2:0], inject & next_row_q[l]};
        track_d[l*DEPTH +: DEPTH] = lane_v;
        jv_d[l]        = hit[l] | miss[l];
        jg_d[2*l +: 2] = hit[l] ? {perf[l], 1'b1} : 2'b00;
        if (hit[l]) begin
          add_score = add_score + (perf[l] ? 32'd3 : 32'd1);
          add_combo = add_combo + 16'd1;
        end
      end
    end
    combo_base = (|miss) ? 16'd0 : combo_q;
    combo_sum  = {1'b0, combo_base} + {1'b0, add_combo};
    combo_d    = combo_sum[16] ? 16'hFFFF : combo_sum[15:0];
    score_sum  = {1'b0, score_q} + {1'b0, add_score};
    score_d    = score_sum[32] ? 32'hFFFF_FFFF : score_sum[31:0];
    max_d      = (combo_d > max_q) ? combo_d : max_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_FETCH;
      ST_FETCH:         if (fetch_q) state_d = ST_RUN;
      ST_RUN:           if (next_end_q && (track_q == '0)) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_q    <= 1'b0;
      refill_q   <= '0;
      cyc_q      <= '0;
      rd_q       <= '0;
      addr_q     <= '0;
      next_row_q <= '0;
      next_end_q <= 1'b0;
      key_q      <= '0;
      track_q    <= '0;
      jv_q       <= '0;
      jg_q       <= '0;
      score_q    <= '0;
      combo_q    <= '0;
      max_q      <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key;
      jv_q    <= jv_d;
      jg_q    <= jg_d;
      if (restart) begin
        fetch_q    <= 1'b0;
        refill_q   <= '0;
        cyc_q      <= '0;
        rd_q       <= '0;
        addr_q     <= '0;
        next_row_q <= '0;
        next_end_q <= 1'b0;
        track_q    <= '0;
        score_q    <= '0;
        combo_q    <= '0;
        max_q      <= '0;
      end else if (state_q == ST_FETCH) begin
        fetch_q <= 1'b1;
        if (fetch_q) begin
          next_row_q <= chart_data;
          next_end_q <= chart_end;
        end
      end else if (run) begin
        track_q <= track_d;
        score_q <= score_d;
        combo_q <= combo_d;
        max_q   <= max_d;
        cyc_q   <= step ? '0 : cyc_q + 1'b1;
        if (step) rd_q <= (rd_q == RD_W'(READ_STEPS - 1)) ? '0 : rd_q + 1'b1;
        // Data for the new address is on chart_data two edges after the increment.
        if (inject) begin
          addr_q   <= addr_q + 1'b1;
          refill_q <= 2'b01;
        end else begin
          refill_q <= {refill_q[0], 1'b0};
        end
        if (refill_q[1]) begin
          next_row_q <= chart_data;
          next_end_q <= chart_end;
        end
      end
    end
  end

  assign chart_addr  = addr_q;
  assign track       = track_q;
  assign judge_valid = jv_q;
  assign judge_grade = jg_q;
  assign score       = score_q;
  assign combo       = combo_q;
  assign max_combo   = max_q;
  assign busy        = (state_q == ST_FETCH) || (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);

endmodule
